fork_sched: RTL
===============

// Module: fork_sched
// PURPOSE
//   Core-pool scheduler for the multi-core tape machine. Collects FORK requests from running
//   cores and picks one requester per grant, round-robin. Assigns it a free core and drives that
//   core's fork_cxt start bundle (the same {start, ptr, pc} word each ALU consumes).
//   Tracks busy/free cores from halt reports and flags program completion.
// PARAMETERS
//   NCORES   4    number of cores (2..16)
//   PC_W     16   program-counter width carried in fork context
//   PTR_W    16   tape-pointer width carried in fork context
// PORTS
//   clk          in   1              system clock, all state on posedge
//   rst          in   1              asynchronous, active-high reset
//   fork_req     in   NCORES         core i requests a fork; held high until fork_ack[i]
//   fork_pc      in   NCORES*PC_W    child start PC from core i, slice [i*PC_W +: PC_W]
//   fork_ptr     in   NCORES*PTR_W   child start tape pointer from core i
//   core_halt    in   NCORES         core i finished; one-cycle pulse
//   fork_ack     out  NCORES         one-cycle grant pulse to requester
//   fork_cxt     out  NCORES*33      per core: [33i+32]=start, [33i+16 +:16]=ptr, [33i +:16]=pc
//   core_busy    out  NCORES         registered busy mask
//   all_halted   out  1              high while core_busy == 0
// BEHAVIOUR
//   Reset: core_busy = 1 (only core 0 running); fork_ack = 0; fork_cxt = 0; rr_ptr = 0;
//     FSM = IDLE. all_halted = 0 follows from core_busy.
//   Requests considered only from busy cores: eligible = fork_req & core_busy.
//   FSM IDLE: if eligible != 0 and ~core_busy != 0:
//     - winner = first eligible index at or after rr_ptr, wrapping modulo NCORES.
//     - target = lowest-index free core.
//     - go to GRANT.
//     Otherwise stay IDLE; requesters wait indefinitely, with no drop and no timeout.
//   FSM GRANT (exactly one cycle, registered outputs):
//     - fork_ack[winner] = 1.
//     - fork_cxt[target] = {1, fork_ptr[winner], fork_pc[winner]}.
//     - core_busy[target] <= 1; rr_ptr <= (winner+1) mod NCORES; then -> IDLE.
//     - No arbitration in GRANT, so a still-high held req is not regranted.
//     - Throughput is 1 fork per 2 cycles. Latency from req to ack/start is 2 cycles.
//   fork_ack and the start bit are high only in GRANT. pc/ptr fields return to 0 with start.
//   core_halt[i] clears core_busy[i] at the next edge. A freed core is eligible as a target from
//     the following IDLE cycle, not in the halt cycle.
//   Halt on an already-free core: ignored.
//   Halt and fork_req from the same core in the same cycle: halt wins, the request is discarded,
//     and no ack is sent.
//   Halt of the winner during GRANT: the ack is still issued and the child still started.
//     The winner is freed.
//   Target set busy and a halt for the same target in the same cycle: cannot occur (the target
//     was free). Busy-set takes priority if forced.
//   all_halted with pending requests cannot occur (requests are masked by busy).
//   Async reset mid-GRANT: the pulse is aborted and state returns to reset values immediately.
// CONFIGURATION
//   FORK_STATS_EN defined: adds outputs fork_count[15:0] and stall_cycles[15:0], reset to 0.
//     - fork_count increments once per GRANT.
//     - stall_cycles increments every IDLE cycle with eligible != 0 and no free core.
//     - Both saturate at 16'hFFFF.
//   FORK_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
//   threadbrain_pkg:
//     - opcode constants: PLUS..PRINT, SYNC, plus FORK = 4'h7.
//     - CXT_W = 33 and field offsets CXT_START = 32, CXT_PTR = 16, CXT_PC = 0.
//     - FSM state enum {IDLE, GRANT}.
//   Sub-module rr_arbiter #(N): inputs req[N], ptr[$clog2(N)]; output one-hot gnt plus index.
//     Purely combinational, reusable for the tape-memory port arbiter.
//   The free-core priority encoder stays inline.
// TESTING
//   1. Reset, no stimulus -> core_busy=4'b0001, all fork_cxt start bits 0, all_halted=0.
//   2. Core 0 req pc=16'h0040 ptr=16'h0090 -> 2 cycles later fork_ack[0]=1 for 1 cycle;
//      fork_cxt[1] = {1, 16'h0090, 16'h0040}; core_busy=4'b0011.
//   3. Cores 0,1,2 busy, all req simultaneously, rr_ptr=0 -> grant 0 (target core 3).
//      Then no free core, so stall_cycles counts while reqs wait. Core 3 halt -> grant to 1.
//   4. Cores 1 and 2 each fork repeatedly with halts freeing targets -> grants alternate 1,2,1,2.
//      Never two acks in consecutive cycles.
//   5. Core 1 pulses core_halt and fork_req in the same cycle -> no ack.
//      core_busy[1]=0 next cycle.
//   6. Halt all busy cores -> all_halted=1. Assert rst during GRANT -> fork_ack and start drop
//      immediately, and fork_count=0 (FORK_STATS_EN).

Source files
------------

// File: rtl/fork_sched_pkg.sv
// Shared definitions for the core-pool fork scheduler: opcode map, fork-context layout, FSM states.
// The context word is the {start, ptr, pc} bundle each ALU consumes at core start.
package fork_sched_pkg;

    localparam logic [3:0] OP_PLUS    = 4'h0;
    localparam logic [3:0] OP_MINUS   = 4'h1;
    localparam logic [3:0] OP_RIGHT   = 4'h2;
    localparam logic [3:0] OP_LEFT    = 4'h3;
    localparam logic [3:0] OP_LOOP    = 4'h4;
    localparam logic [3:0] OP_ENDLOOP = 4'h5;
    localparam logic [3:0] OP_PRINT   = 4'h6;
    localparam logic [3:0] OP_FORK    = 4'h7;
    localparam logic [3:0] OP_SYNC    = 4'h8;

    localparam int CXT_W       = 33;
    localparam int CXT_START   = 32;
    localparam int CXT_PTR     = 16;
    localparam int CXT_PC      = 0;
    localparam int CXT_FIELD_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [CXT_W-1:0] pack_cxt(input logic [CXT_FIELD_W-1:0] ptr,
                                                  input logic [CXT_FIELD_W-1:0] pc);
        logic [CXT_W-1:0] v;
        v                          = '0;
        v[CXT_START]               = 1'b1;
        v[CXT_PTR +: CXT_FIELD_W]  = ptr;
        v[CXT_PC  +: CXT_FIELD_W]  = pc;
        return v;
    endfunction

endpackage

// File: rtl/fork_sched_if.sv
// Fork request / grant bundle between the core array (master) and the scheduler (slave).
// FORK_STATS_EN adds the fork_count / stall_cycles statistics outputs.
interface fork_sched_if
    import fork_sched_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int PC_W   = 16,
    parameter int PTR_W  = 16
);
    logic [NCORES-1:0]       fork_req;
    logic [NCORES*PC_W-1:0]  fork_pc;
    logic [NCORES*PTR_W-1:0] fork_ptr;
    logic [NCORES-1:0]       core_halt;
    logic [NCORES-1:0]       fork_ack;
    logic [NCORES*CXT_W-1:0] fork_cxt;
    logic [NCORES-1:0]       core_busy;
    logic                    all_halted;
`ifdef FORK_STATS_EN
    logic [15:0]             fork_count;
    logic [15:0]             stall_cycles;
`endif

    modport master (
        output fork_req, fork_pc, fork_ptr, core_halt,
        input  fork_ack, fork_cxt, core_busy, all_halted
`ifdef FORK_STATS_EN
        , input fork_count, stall_cycles
`endif
    );

    modport slave (
        input  fork_req, fork_pc, fork_ptr, core_halt,
        output fork_ack, fork_cxt, core_busy, all_halted
`ifdef FORK_STATS_EN
        , output fork_count, stall_cycles
`endif
    );

endinterface

// File: rtl/fork_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after i_ptr, wrapping modulo N.
// Shared with the tape-memory port arbiter, so it carries no scheduler-specific logic.
module fork_sched_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    always_comb begin
        int            jj;
        logic [IW-1:0] j;
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        jj    = 0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            jj = int'(i_ptr) + k;
            if (jj >= N) jj = jj - N;
            j = IW'(jj);
            if (!o_vld && i_req[j]) begin
                o_vld    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = j;
            end
        end
    end

endmodule

// File: rtl/fork_sched.sv
// Core-pool fork scheduler: round-robin pick of a forking core, start of the lowest free core.
// Optional FORK_STATS_EN adds saturating fork_count and stall_cycles counters.
module fork_sched
    import fork_sched_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int PC_W   = 16,
    parameter int PTR_W  = 16
) (
    input logic         clk,
    input logic         rst,
    fork_sched_if.slave bus
);
    localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;

    state_t                  r_state;
    logic [NCORES-1:0]       r_busy;
    logic [NCORES-1:0]       r_ack;
    logic [NCORES-1:0]       r_tgt_oh;
    logic [NCORES*CXT_W-1:0] r_cxt;
    logic [IDX_W-1:0]        r_rr;
    logic [IDX_W-1:0]        r_winner;

    logic [NCORES-1:0]       w_eligible;
    logic [NCORES-1:0]       w_arb_gnt;
    logic [NCORES-1:0]       w_free_oh;
    logic [IDX_W-1:0]        w_winner;
    logic                    w_arb_vld;
    logic                    w_free_vld;
    logic                    w_go;
    logic [PC_W-1:0]         w_pc;
    logic [PTR_W-1:0]        w_ptr;
    logic [NCORES*CXT_W-1:0] w_cxt;

    // A core halting this cycle loses its request: halt wins over fork.
    assign w_eligible = bus.fork_req & r_busy & ~bus.core_halt;

    fork_sched_rr_arbiter #(.N(NCORES), .IW(IDX_W)) u_rr_arbiter (
        .i_req (w_eligible),
        .i_ptr (r_rr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_winner),
        .o_vld (w_arb_vld)
    );

    always_comb begin
        w_free_oh  = '0;
        w_free_vld = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (!r_busy[i] && !w_free_vld) begin
                w_free_oh[i] = 1'b1;
                w_free_vld   = 1'b1;
            end
        end
    end

    always_comb begin
        w_pc  = '0;
        w_ptr = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_arb_gnt[i]) begin
                w_pc  = bus.fork_pc[i*PC_W +: PC_W];
                w_ptr = bus.fork_ptr[i*PTR_W +: PTR_W];
            end
        end
    end

    always_comb begin
        w_cxt = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_free_oh[i]) w_cxt[i*CXT_W +: CXT_W] = pack_cxt(16'(w_ptr), 16'(w_pc));
        end
    end

    assign w_go = (r_state == IDLE) && w_arb_vld && w_free_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_busy   <= NCORES'(1);
            r_ack    <= '0;
            r_tgt_oh <= '0;
            r_cxt    <= '0;
            r_rr     <= '0;
            r_winner <= '0;
        end else begin
            r_ack <= '0;
            r_cxt <= '0;
            case (r_state)
                IDLE: begin
                    r_busy <= r_busy & ~bus.core_halt;
                    if (w_go) begin
                        r_state  <= GRANT;
                        r_ack    <= w_arb_gnt;
                        r_cxt    <= w_cxt;
                        r_winner <= w_winner;
                        r_tgt_oh <= w_free_oh;
                    end
                end
                GRANT: begin
                    // Target busy-set overrides any halt aimed at the same core.
                    r_busy  <= (r_busy & ~bus.core_halt) | r_tgt_oh;
                    r_rr    <= (r_winner == IDX_W'(NCORES - 1)) ? '0 : r_winner + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fork_ack   = r_ack;
    assign bus.fork_cxt   = r_cxt;
    assign bus.core_busy  = r_busy;
    assign bus.all_halted = ~|r_busy;

`ifdef FORK_STATS_EN
    logic [15:0] r_fork_count;
    logic [15:0] r_stall_cycles;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fork_count   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (r_state == GRANT) r_fork_count <= sat_inc(r_fork_count);
            if (r_state == IDLE && w_arb_vld && !w_free_vld) r_stall_cycles <= sat_inc(r_stall_cycles);
        end
    end

    assign bus.fork_count   = r_fork_count;
    assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule
